// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit ALU. It registers the
// ALU inputs, waits EXEC_CYCLES for settling, then returns result and flags.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_ctrl,
  input  logic [5:0]  req_bonus,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  alu_bonus,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_cout,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_cout,
  output logic        rsp_overflow,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t      state;
  logic        last_grant;
  logic [3:0]  cnt;

  logic        winner;
  logic [3:0]  sel_ctrl;
  logic [2:0]  sel_bonus;
  logic [31:0] sel_src1;
  logic [31:0] sel_src2;

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b1100, 4'b1101, 4'b0111: is_legal = 1'b1;
      default:                   is_legal = 1'b0;
    endcase
  endfunction

  // On a tie the grant alternates away from the previous winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    winner    = 1'b0;
    req_ready = 2'b00;
    if (&req_valid) winner = ~last_grant;
    else            winner = req_valid[1];
    sel_ctrl  = winner ? req_ctrl[7:4]   : req_ctrl[3:0];
    sel_bonus = winner ? req_bonus[5:3]  : req_bonus[2:0];
    sel_src1  = winner ? req_src1[63:32] : req_src1[31:0];
    sel_src2  = winner ? req_src2[63:32] : req_src2[31:0];
    // Gated by rst_n so the handshake is also silent while reset is held.
    if (rst_n && state == IDLE && |req_valid)
      req_ready = winner ? 2'b10 : 2'b01;
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cnt          <= '0;
      alu_src1     <= '0;
      alu_src2     <= '0;
      alu_ctrl     <= '0;
      alu_bonus    <= '0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            last_grant <= winner;
            rsp_id     <= winner;
            if (is_legal(sel_ctrl)) begin
              alu_src1  <= sel_src1;
              alu_src2  <= sel_src2;
              alu_ctrl  <= sel_ctrl;
              alu_bonus <= sel_bonus;
              cnt       <= '0;
              state     <= EXEC;
            end else begin
              rsp_result   <= '0;
              rsp_zero     <= 1'b0;
              rsp_cout     <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_err      <= 1'b1;
              state        <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt == LAST_CNT) begin
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_cout     <= alu_cout;
            rsp_overflow <= alu_overflow;
            rsp_err      <= 1'b0;
            state        <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
